tt_sweep_ctrl: RTL

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all 8 vectors into a 3-input gate and captures its code.
// Define TT_SWEEP_ERRCNT_EN to add err_cnt, a saturating count of mismatching sweeps.
module tt_sweep_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       gate_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] signature,
   output logic       pass
`ifdef TT_SWEEP_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   localparam logic [3:0] SET_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sig_q, sig_d;
   logic [7:0] exp_q, exp_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic [2:0] vec_q, vec_d;
`ifdef TT_SWEEP_ERRCNT_EN
   logic [7:0] err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sig_d   = sig_q;
      exp_d   = exp_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               exp_d   = expected;
               sig_d   = 8'h00;
               pass_d  = 1'b0;
               idx_d   = 3'd0;
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = 4'd0;
               state_d = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_IDLE;
            end else if (cnt_q == SET_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               pass_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               sig_d[idx_q] = gate_out;
               if (idx_q == 3'd7) begin
                  // pass is resolved on entry so it is valid alongside done
                  pass_d  = (sig_d == exp_q);
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_APPLY;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      vec_d  = 3'd0;
      if ((state_d == S_APPLY) || (state_d == S_SETTLE) ||
          (state_d == S_SAMPLE))
         vec_d = idx_d;
   end

`ifdef TT_SWEEP_ERRCNT_EN
   always_comb begin
      err_d = err_q;
      if (done_d && !pass_d && (err_q != 8'hFF))
         err_d = err_q + 8'd1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         sig_q   <= 8'h00;
         exp_q   <= 8'h00;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         vec_q   <= 3'd0;
`ifdef TT_SWEEP_ERRCNT_EN
         err_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         vec_q   <= vec_d;
`ifdef TT_SWEEP_ERRCNT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign in1       = vec_q[2];
   assign in2       = vec_q[1];
   assign in3       = vec_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign signature = sig_q;
   assign pass      = pass_q;
`ifdef TT_SWEEP_ERRCNT_EN
   assign err_cnt   = err_q;
`endif

endmodule
